// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants and FSM encoding for the snake body shifter
package snake_pkg;

  localparam int unsigned SNAKE_BODY_BASE     = 110;
  localparam int unsigned SNAKE_MAX_SEGMENTS  = 20;
  localparam int unsigned SNAKE_POS_W         = 11;
  localparam int unsigned SNAKE_LENGTH1_INDEX = 102;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HEAD  = 2'd2,
    ST_DONE  = 2'd3
  } shift_state_e;

endpackage

// File: rtl/snake_body_shifter_if.sv
// rtl/snake_body_shifter_if.sv - processor, command and register-file write port bundle
interface snake_body_shifter_if
  import snake_pkg::*;
#(
  parameter int unsigned MAX_SEGMENTS = SNAKE_MAX_SEGMENTS,
  parameter int unsigned POS_WIDTH    = SNAKE_POS_W
);

  logic                              cpu_enable;
  logic [31:0]                       cpu_index;
  logic [31:0]                       cpu_value;
  logic                              cmd_start;
  logic [POS_WIDTH-1:0]              new_head;
  logic [31:0]                       length_in;
  logic [MAX_SEGMENTS*POS_WIDTH-1:0] body_in;
  logic                              reg_enable;
  logic [31:0]                       reg_index;
  logic [31:0]                       reg_value;
  logic                              busy;
  logic                              done;
  logic                              cpu_stall;

  // Processor / game-logic side
  modport master (
    output cpu_enable, cpu_index, cpu_value, cmd_start, new_head, length_in, body_in,
    input  reg_enable, reg_index, reg_value, busy, done, cpu_stall
  );

  // Shifter side
  modport slave (
    input  cpu_enable, cpu_index, cpu_value, cmd_start, new_head, length_in, body_in,
    output reg_enable, reg_index, reg_value, busy, done, cpu_stall
  );

endinterface

// File: rtl/snake_body_shifter.sv
// rtl/snake_body_shifter.sv - sequenced one-step body shift in front of the snake register file
module snake_body_shifter
  import snake_pkg::*;
#(
  parameter int unsigned BASE_INDEX   = SNAKE_BODY_BASE,
  parameter int unsigned MAX_SEGMENTS = SNAKE_MAX_SEGMENTS,
  parameter int unsigned POS_WIDTH    = SNAKE_POS_W
) (
  input  logic                 clock,
  input  logic                 reset,
  snake_body_shifter_if.slave  sif
);

  shift_state_e         state_q;
  logic [4:0]           k_q;
  logic [POS_WIDTH-1:0] head_q;
  logic                 busy_q;
  logic                 done_q;

  logic [4:0]           len_clamp;
  logic [4:0]           seg_rd;
  logic [POS_WIDTH-1:0] seg_val;
  logic [POS_WIDTH-1:0] seg_arr [MAX_SEGMENTS];

  // Unpack the live body bus into per-segment positions
  for (genvar g = 0; g < int'(MAX_SEGMENTS); g++) begin : g_seg
    assign seg_arr[g] = sif.body_in[POS_WIDTH*g +: POS_WIDTH];
  end

  // Clamp the length on the full 32-bit value, then pick segment k-1 as the source
  always_comb begin
    len_clamp = 5'd0;
    if (sif.length_in > 32'(MAX_SEGMENTS)) begin
      len_clamp = 5'(MAX_SEGMENTS);
    end else begin
      len_clamp = sif.length_in[4:0];
    end
    seg_rd  = k_q - 5'd1;
    seg_val = '0;
    if ({27'd0, seg_rd} < 32'(MAX_SEGMENTS)) begin
      seg_val = seg_arr[seg_rd];
    end
  end

  // Sequencer: latch command, walk k downward from L-1 to 1, then head, then a done pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= 5'd0;
      head_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (sif.cmd_start) begin
            head_q  <= sif.new_head;
            k_q     <= len_clamp - 5'd1;
            busy_q  <= 1'b1;
            state_q <= (len_clamp >= 5'd2) ? ST_SHIFT : ST_HEAD;
          end
        end
        ST_SHIFT: begin
          k_q <= k_q - 5'd1;
          if (k_q == 5'd1) begin
            state_q <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Single write port: CPU pass-through when idle, shifter writes otherwise, quiet in reset
  always_comb begin
    sif.reg_enable = 1'b0;
    sif.reg_index  = 32'd0;
    sif.reg_value  = 32'd0;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          sif.reg_enable = sif.cpu_enable;
          sif.reg_index  = sif.cpu_index;
          sif.reg_value  = sif.cpu_value;
        end
        ST_SHIFT: begin
          sif.reg_enable = 1'b1;
          sif.reg_index  = 32'(BASE_INDEX) + {27'd0, k_q};
          sif.reg_value  = 32'(seg_val);
        end
        ST_HEAD: begin
          sif.reg_enable = 1'b1;
          sif.reg_index  = 32'(BASE_INDEX);
          sif.reg_value  = 32'(head_q);
        end
        default: begin
          sif.reg_enable = 1'b0;
        end
      endcase
    end
  end

  // Status: any CPU write during a sequence is refused rather than queued
  always_comb begin
    sif.busy      = busy_q;
    sif.done      = done_q;
    sif.cpu_stall = reset & busy_q & sif.cpu_enable;
  end

endmodule
